param_bus_core: RTL and testbench
=================================

Name: param_bus_core

Overview:
- Parametrised successor to the 8-bit bus CPU.
- Executes 8-bit instructions (2-bit opcode + 6-bit field) from an internal instruction RAM that is loaded serially over ram_data_in.
- Datapath width and program-memory depth are generic.
- Adds ALU compute ops, conditional jumps on r3, a valid/ready input handshake and an output-valid strobe.
- Top-level CPU block, driven by the bench/host through load and run controls.

Parameters:
DATA_W, 8, register/ALU/IO width (>=8)
ADDR_W, 8, instruction RAM address width; depth = 2**ADDR_W

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
ram_we  input  1  1 = program-load mode; writes ram_data_in each cycle
ram_data_in  input  8  instruction word being loaded
pc_recount  input  1  1-cycle pulse: pc<=0 and start/restart execution
data_in  input  DATA_W  external input operand
in_valid  input  1  data_in is valid
in_ready  output  1  data_in consumed this cycle
data_out  output  DATA_W  last value written to output register
out_valid  output  1  1-cycle strobe, data_out updated
pc  output  ADDR_W  current program counter
running  output  1  1 while in FETCH/EXEC/WAIT_IN

Behaviour:
- Reset (rst=0, async):
  - r0..r5, data_out, pc, wr_ptr all 0.
  - out_valid=0, in_ready=0.
  - State IDLE.
  - RAM contents undefined.
- State machine: IDLE, LOAD, FETCH, EXEC, WAIT_IN.
- ram_we priority:
  - ram_we=1 in any state forces LOAD next cycle and aborts execution.
  - Registers are kept.
  - pc_recount is ignored while ram_we=1.
- LOAD:
  - Each rising edge with ram_we=1: imem[wr_ptr]<=ram_data_in, wr_ptr<=wr_ptr+1.
  - wr_ptr wraps modulo 2**ADDR_W.
  - ram_we=0: go to IDLE.
- pc_recount=1 with ram_we=0, any state: pc<=0, wr_ptr<=0, next state FETCH.
- FETCH: synchronous RAM read of imem[pc] into ir; next state EXEC. Each instruction takes 2 cycles (FETCH+EXEC), plus any WAIT_IN stall.
- EXEC decodes ir[7:6]:
  - 00 immediate: r0 <= zero-extend(ir[5:0]).
  - 01 compute on ir[2:0], result to r3, all modulo 2**DATA_W:
    - 000 OR, 001 NAND, 010 NOR, 011 AND, 100 ADD r1+r2, 101 SUB r1-r2.
    - 110/111: no-op.
  - 10 copy, src=ir[5:3], dst=ir[2:0]:
    - src 000-101 = r0-r5; 110 = data_in; 111 reads 0.
    - dst 000-101 = r0-r5; 110 = data_out with out_valid=1 for that cycle; 111 discards.
  - 11 condition on r3 (signed), ir[2:0]:
    - 000 never, 001 =0, 010 <0, 011 <=0, 100 always, 101 !=0, 110 >=0, 111 >0.
    - Taken: pc <= r0[ADDR_W-1:0]. Not taken: pc+1.
- pc increment for every non-jump instruction; pc wraps to 0 after 2**ADDR_W-1.
- Input handshake:
  - Copy with src=110 and in_valid=1: in_ready=1 combinationally in EXEC; transfer completes.
  - in_valid=0: go to WAIT_IN, hold pc, in_ready=0.
  - In WAIT_IN, the first cycle with in_valid=1: in_ready=1, complete the copy, pc+1, go to FETCH.
  - in_ready is never 1 outside these cases.
- Copy 110->110: input passes through to data_out, with both in_ready and out_valid asserted.
- out_valid:
  - Registered, high exactly one cycle per output write.
  - data_out holds its value until the next output write or reset.
- EXEC always goes to FETCH, unless it enters WAIT_IN.
- IDLE and LOAD do not change pc or registers (except wr_ptr in LOAD).
- Reset mid-instruction: immediate return to the reset state; a pending input is not consumed.

Test Plan:
- Load 00_000101, 10_000_110, then pc_recount → out_valid pulses once with data_out=5; pc advances 0,1,2.
- Load 00_000011, 10_000_001, 00_000100, 10_000_010, 01_000_100, 10_011_110 → data_out=7. Change the compute op to 101 → data_out=8'hFF (3-4 wrap).
- Copy 10_110_000 with in_valid=0 for 4 cycles, then data_in=8'h2A, in_valid=1 → pc holds during the stall; in_ready pulses in exactly one cycle; r0=0x2A.
- Loop program: 00_000000, 10_000_011, 11_000_001 → jump taken on r3=0, pc returns to 0 repeatedly. Change to 11_000_101 → falls through to pc=3.
- Load 2**ADDR_W+1 words (ADDR_W=3) → wr_ptr wraps; imem[0] holds the 9th word.
- ram_we=1 asserted mid-execution → running=0 next cycle and loading resumes. pc_recount with ram_we=1 is ignored. Assert rst=0 mid-EXEC → all outputs 0 asynchronously.

Source files
------------

// File: rtl/param_bus_core.sv
// Parametrised bus CPU: 8-bit instructions from a serially loaded instruction RAM,
// DATA_W-wide registers r0..r5, ALU ops, conditional jumps on r3, valid/ready input.
module param_bus_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ram_we,
    input  logic [7:0]        ram_data_in,
    input  logic              pc_recount,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              running
);

    typedef enum logic [2:0] {IDLE, LOAD, FETCH, EXEC, WAIT_IN} state_t;

    localparam int DEPTH = 2 ** ADDR_W;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [7:0]        ir_q, ir_d;
    logic [DATA_W-1:0] regs_q [6];
    logic [DATA_W-1:0] regs_d [6];
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        imem_q [DEPTH];

    logic [1:0]        opcode;
    logic [2:0]        src, dst;
    logic              step_ok, input_copy, copy_fire, jump_taken, r3_zero, r3_neg;
    logic [DATA_W-1:0] alu_res, copy_val, imm_val;
    logic [ADDR_W-1:0] jump_target, pc_inc;

    assign opcode     = ir_q[7:6];
    assign src        = ir_q[5:3];
    assign dst        = ir_q[2:0];
    assign step_ok    = !ram_we && !pc_recount;
    assign input_copy = (opcode == 2'b10) && (src == 3'b110);
    assign imm_val    = DATA_W'(ir_q[5:0]);
    assign pc_inc     = pc_q + ADDR_W'(1);
    assign r3_zero    = (regs_q[3] == '0);
    assign r3_neg     = regs_q[3][DATA_W-1];

    generate
        if (DATA_W >= ADDR_W) begin : g_tgt_slice
            assign jump_target = regs_q[0][ADDR_W-1:0];
        end else begin : g_tgt_ext
            assign jump_target = ADDR_W'(regs_q[0]);
        end
    endgenerate

    // A copy completes in EXEC when its input is available, otherwise later from WAIT_IN.
    assign copy_fire = step_ok &&
                       (((state_q == EXEC) && (opcode == 2'b10) && (!input_copy || in_valid)) ||
                        ((state_q == WAIT_IN) && in_valid));

    always_comb begin
        alu_res = '0;
        case (ir_q[2:0])
            3'b000:  alu_res = regs_q[1] | regs_q[2];
            3'b001:  alu_res = ~(regs_q[1] & regs_q[2]);
            3'b010:  alu_res = ~(regs_q[1] | regs_q[2]);
            3'b011:  alu_res = regs_q[1] & regs_q[2];
            3'b100:  alu_res = regs_q[1] + regs_q[2];
            3'b101:  alu_res = regs_q[1] - regs_q[2];
            default: alu_res = regs_q[3];
        endcase
    end

    always_comb begin
        copy_val = '0;
        case (src)
            3'b110:  copy_val = data_in;
            3'b111:  copy_val = '0;
            default: copy_val = regs_q[src];
        endcase
    end

    always_comb begin
        jump_taken = 1'b0;
        case (ir_q[2:0])
            3'b000: jump_taken = 1'b0;
            3'b001: jump_taken = r3_zero;
            3'b010: jump_taken = r3_neg;
            3'b011: jump_taken = r3_neg || r3_zero;
            3'b100: jump_taken = 1'b1;
            3'b101: jump_taken = !r3_zero;
            3'b110: jump_taken = !r3_neg;
            3'b111: jump_taken = !r3_neg && !r3_zero;
        endcase
    end

    // Next-state logic: loading always wins, then a restart request.
    always_comb begin
        state_d = state_q;
        if (ram_we) begin
            state_d = LOAD;
        end else if (pc_recount) begin
            state_d = FETCH;
        end else begin
            case (state_q)
                LOAD:    state_d = IDLE;
                FETCH:   state_d = EXEC;
                EXEC:    state_d = (input_copy && !in_valid) ? WAIT_IN : FETCH;
                WAIT_IN: state_d = in_valid ? FETCH : WAIT_IN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        pc_d        = pc_q;
        wr_ptr_d    = wr_ptr_q;
        ir_d        = ir_q;
        regs_d      = regs_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        if (ram_we) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end else if (pc_recount) begin
            pc_d     = '0;
            wr_ptr_d = '0;
        end else begin
            case (state_q)
                FETCH: ir_d = imem_q[pc_q];
                EXEC: begin
                    case (opcode)
                        2'b00: begin
                            regs_d[0] = imm_val;
                            pc_d      = pc_inc;
                        end
                        2'b01: begin
                            if (ir_q[2:1] != 2'b11) regs_d[3] = alu_res;
                            pc_d = pc_inc;
                        end
                        2'b10: if (copy_fire) pc_d = pc_inc;
                        default: pc_d = jump_taken ? jump_target : pc_inc;
                    endcase
                end
                WAIT_IN: if (in_valid) pc_d = pc_inc;
                default: ;
            endcase
        end
        if (copy_fire) begin
            case (dst)
                3'b110: begin
                    data_out_d  = copy_val;
                    out_valid_d = 1'b1;
                end
                3'b111:  ;
                default: regs_d[dst] = copy_val;
            endcase
        end
    end

    always_comb begin
        in_ready = step_ok && in_valid &&
                   (((state_q == EXEC) && input_copy) || (state_q == WAIT_IN));
        running  = (state_q == FETCH) || (state_q == EXEC) || (state_q == WAIT_IN);
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign pc        = pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            wr_ptr_q    <= '0;
            ir_q        <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 6; i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            wr_ptr_q    <= wr_ptr_d;
            ir_q        <= ir_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            regs_q      <= regs_d;
        end
    end

    // Instruction RAM has no reset; its contents are only defined once loaded.
    always_ff @(posedge clk) begin
        if (ram_we) imem_q[wr_ptr_q] <= ram_data_in;
    end

endmodule

// File: tb/tb_param_bus_core.sv
// Bench for param_bus_core (ADDR_W=3): scenario tasks with inline checks and an
// output scoreboard popped whenever out_valid strobes.
module tb_param_bus_core;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              ram_we = 1'b0;
    logic [7:0]        ram_data_in = '0;
    logic              pc_recount = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic [ADDR_W-1:0] pc;
    logic              running;

    int errors = 0;
    int checks = 0;

    logic [7:0]        prog [$];
    logic [DATA_W-1:0] sb [$];
    logic [DATA_W-1:0] mon_exp;

    param_bus_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .ram_we(ram_we), .ram_data_in(ram_data_in),
        .pc_recount(pc_recount), .data_in(data_in), .in_valid(in_valid),
        .in_ready(in_ready), .data_out(data_out), .out_valid(out_valid),
        .pc(pc), .running(running)
    );

    always #5 clk = ~clk;

    // Every output strobe must match the oldest expected value.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_out_valid: data_out=%0h, required no output", data_out);
            end else begin
                mon_exp = sb.pop_front();
                if (data_out !== mon_exp) begin
                    errors++;
                    $display("[TB] FAIL data_out: got %0h, required %0h", data_out, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0; ram_we = 1'b0; pc_recount = 1'b0; in_valid = 1'b0; data_in = '0;
        sb.delete();
        #3;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic load_prog();
        foreach (prog[i]) begin
            @(negedge clk);
            ram_we = 1'b1;
            ram_data_in = prog[i];
        end
        @(negedge clk);
        ram_we = 1'b0;
    endtask

    task automatic start_prog();
        @(negedge clk);
        pc_recount = 1'b1;
        @(negedge clk);
        pc_recount = 1'b0;
    endtask

    task automatic wait_outputs(input int budget, input string name);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_outputs: pending=%0d, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        checks += 5;
        if (data_out !== '0)  begin errors++; $display("[TB] FAIL reset_data_out: got %0h, required 0", data_out); end
        if (out_valid !== 0)  begin errors++; $display("[TB] FAIL reset_out_valid: got %0b, required 0", out_valid); end
        if (in_ready !== 0)   begin errors++; $display("[TB] FAIL reset_in_ready: got %0b, required 0", in_ready); end
        if (pc !== '0)        begin errors++; $display("[TB] FAIL reset_pc: got %0d, required 0", pc); end
        if (running !== 0)    begin errors++; $display("[TB] FAIL reset_running: got %0b, required 0", running); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_immediate_output();
        logic [ADDR_W-1:0] exp_pc;
        do_reset();
        prog = '{8'b00_000101, 8'b10_000_110, 8'b00_000010, 8'b11_000_100};
        sb.push_back(8'd5);
        load_prog();
        start_prog();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            exp_pc = ADDR_W'(i / 2);
            checks++;
            if (pc !== exp_pc) begin
                errors++;
                $display("[TB] FAIL imm_pc_step%0d: got %0d, required %0d", i, pc, exp_pc);
            end
        end
        wait_outputs(10, "imm");
    endtask

    task automatic run_compute(input logic [5:0] a, input logic [5:0] b, input logic [2:0] op,
                               input logic [7:0] exp_v);
        do_reset();
        prog = '{{2'b00, a}, 8'b10_000_001, {2'b00, b}, 8'b10_000_010,
                 {5'b01_000, op}, 8'b10_011_110, 8'b00_000110, 8'b11_000_100};
        sb.push_back(exp_v);
        load_prog();
        start_prog();
        wait_outputs(40, "compute");
    endtask

    task automatic test_compute();
        logic [7:0] ea, eb, ev;
        run_compute(6'd3, 6'd4, 3'b100, 8'd7);
        run_compute(6'd3, 6'd4, 3'b101, 8'hFF);
        ea = 8'h35;
        eb = 8'h1C;
        for (int op = 0; op < 7; op++) begin
            case (op)
                0: ev = ea | eb;
                1: ev = ~(ea & eb);
                2: ev = ~(ea | eb);
                3: ev = ea & eb;
                4: ev = ea + eb;
                5: ev = ea - eb;
                default: ev = 8'h00;
            endcase
            run_compute(6'h35, 6'h1C, 3'(op), ev);
        end
    endtask

    task automatic test_stall();
        do_reset();
        prog = '{8'b10_110_000, 8'b10_000_110, 8'b00_000010, 8'b11_000_100};
        sb.push_back(8'h2A);
        load_prog();
        start_prog();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_exec_ready: got %0b, required 0", in_ready); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks += 2;
            if (pc !== '0)       begin errors++; $display("[TB] FAIL stall_pc%0d: got %0d, required 0", i, pc); end
            if (in_ready !== 0)  begin errors++; $display("[TB] FAIL stall_ready%0d: got %0b, required 0", i, in_ready); end
        end
        data_in = 8'h2A;
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_ready_pulse: got %0b, required 1", in_ready); end
        tick();
        checks += 2;
        if (pc !== ADDR_W'(1)) begin errors++; $display("[TB] FAIL stall_pc_after: got %0d, required 1", pc); end
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_ready_after: got %0b, required 0", in_ready); end
        in_valid = 1'b0;
        wait_outputs(20, "stall");
    endtask

    task automatic test_passthrough();
        do_reset();
        prog = '{8'b10_110_110, 8'b00_000001, 8'b11_000_100};
        data_in = 8'h5C;
        in_valid = 1'b1;
        sb.push_back(8'h5C);
        load_prog();
        start_prog();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL pass_fetch_ready: got %0b, required 0", in_ready); end
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL pass_exec_ready: got %0b, required 1", in_ready); end
        tick();
        in_valid = 1'b0;
        wait_outputs(10, "pass");
    endtask

    task automatic test_jump(input bit taken);
        logic [ADDR_W-1:0] exp_pc;
        int n;
        do_reset();
        prog = '{8'b00_000000, 8'b10_000_011, taken ? 8'b11_000_001 : 8'b11_000_101,
                 8'b00_000011, 8'b11_000_100};
        load_prog();
        start_prog();
        n = taken ? 12 : 8;
        for (int i = 0; i < n; i++) begin
            if (i > 0) tick();
            exp_pc = taken ? ADDR_W'((i / 2) % 3) : ADDR_W'(i / 2);
            checks++;
            if (pc !== exp_pc) begin
                errors++;
                $display("[TB] FAIL jump_t%0b_pc_step%0d: got %0d, required %0d", taken, i, pc, exp_pc);
            end
        end
    endtask

    task automatic test_conditions();
        logic [5:0] av [3];
        logic [5:0] bv [3];
        int d;
        bit tk;
        logic [ADDR_W-1:0] exp_pc;
        av = '{6'd5, 6'd3, 6'd5};
        bv = '{6'd5, 6'd5, 6'd3};
        for (int c = 0; c < 8; c++) begin
            for (int p = 0; p < 3; p++) begin
                d = int'(av[p]) - int'(bv[p]);
                case (c)
                    0: tk = 0;
                    1: tk = (d == 0);
                    2: tk = (d < 0);
                    3: tk = (d <= 0);
                    4: tk = 1;
                    5: tk = (d != 0);
                    6: tk = (d >= 0);
                    default: tk = (d > 0);
                endcase
                exp_pc = tk ? ADDR_W'(2) : ADDR_W'(7);
                do_reset();
                prog = '{{2'b00, av[p]}, 8'b10_000_001, {2'b00, bv[p]}, 8'b10_000_010,
                         8'b01_000_101, 8'b00_000010, {5'b11_000, 3'(c)}, 8'b00_000000};
                load_prog();
                start_prog();
                repeat (14) tick();
                checks++;
                if (pc !== exp_pc) begin
                    errors++;
                    $display("[TB] FAIL cond%0d_d%0d: pc got %0d, required %0d", c, d, pc, exp_pc);
                end
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        prog = '{8'b00_000001, 8'b10_000_110, 8'b00_000010, 8'b11_000_100,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'b00_000111};
        sb.push_back(8'd7);
        load_prog();
        start_prog();
        wait_outputs(20, "wrap");
    endtask

    task automatic test_abort();
        do_reset();
        prog = '{8'b00_000000, 8'b10_000_011, 8'b11_000_001, 8'b00_000011, 8'b11_000_100};
        load_prog();
        start_prog();
        repeat (3) tick();
        ram_we = 1'b1;
        pc_recount = 1'b1;
        ram_data_in = 8'h00;
        tick();
        checks += 2;
        if (running !== 1'b0)  begin errors++; $display("[TB] FAIL abort_running: got %0b, required 0", running); end
        if (pc !== ADDR_W'(1)) begin errors++; $display("[TB] FAIL abort_pc: got %0d, required 1", pc); end
        tick();
        ram_we = 1'b0;
        pc_recount = 1'b0;
        tick();
        checks += 2;
        if (running !== 1'b0)  begin errors++; $display("[TB] FAIL abort_idle_running: got %0b, required 0", running); end
        if (pc !== ADDR_W'(1)) begin errors++; $display("[TB] FAIL abort_idle_pc: got %0d, required 1", pc); end
        start_prog();
        checks += 2;
        if (running !== 1'b1) begin errors++; $display("[TB] FAIL restart_running: got %0b, required 1", running); end
        if (pc !== '0)        begin errors++; $display("[TB] FAIL restart_pc: got %0d, required 0", pc); end
    endtask

    task automatic test_async_reset();
        do_reset();
        prog = '{8'b00_000101, 8'b10_000_110, 8'b10_110_000, 8'b00_000011, 8'b11_000_100};
        sb.push_back(8'd5);
        load_prog();
        start_prog();
        repeat (5) tick();
        checks++;
        if (sb.size() != 0) begin errors++; $display("[TB] FAIL areset_prior_output: pending=%0d, required 0", sb.size()); end
        data_in = 8'h77;
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL areset_ready_before: got %0b, required 1", in_ready); end
        rst = 1'b0;
        #1;
        checks += 5;
        if (data_out !== '0) begin errors++; $display("[TB] FAIL areset_data_out: got %0h, required 0", data_out); end
        if (pc !== '0)       begin errors++; $display("[TB] FAIL areset_pc: got %0d, required 0", pc); end
        if (running !== 0)   begin errors++; $display("[TB] FAIL areset_running: got %0b, required 0", running); end
        if (out_valid !== 0) begin errors++; $display("[TB] FAIL areset_out_valid: got %0b, required 0", out_valid); end
        if (in_ready !== 0)  begin errors++; $display("[TB] FAIL areset_in_ready: got %0b, required 0", in_ready); end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_immediate_output();
        test_compute();
        test_stall();
        test_passthrough();
        test_jump(1'b1);
        test_jump(1'b0);
        test_conditions();
        test_wrap();
        test_abort();
        test_async_reset();
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
